spi_flash_responder: RTL and testbench
======================================

# spi_flash_responder

Synthesizable single-lane SPI (mode 0) NOR-flash target that answers the command set issued by the SPI flash master wrapper. It oversamples the SPI bus in the system clock domain, decodes command/address/dummy/data phases and drives MISO. Memory contents live in an external synchronous byte RAM reached through a simple memory port. It replaces the behavioural flash model in FPGA/emulation builds.

## Interface
- MEM_AW, 18, byte address width of the backing RAM (256 KiB)
- MFR_ID, 8'h20, manufacturer byte returned by RDID
- DEVICE_ID, 16'hBA19, device bytes returned by RDID (MSB first)

- clk  in  1  system clock; one clock domain, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- sclk_i  in  1  SPI clock from master (async, synchronized internally)
- cs_n_i  in  1  chip select, active low (async, synchronized)
- mosi_i  in  1  master-out data (async, synchronized)
- miso_o  out  1  target-out data
- miso_oe_o  out  1  MISO output enable (1 only while in an output phase)
- mem_addr_o  out  MEM_AW  RAM byte address
- mem_rd_o  out  1  one-cycle read strobe; mem_rdata_i valid the next clk
- mem_rdata_i  in  8  RAM read data
- mem_wr_o  out  1  one-cycle write strobe
- mem_wdata_o  out  8  RAM write data
- busy_o  out  1  synced cs_n low
- wel_o  out  1  write-enable latch
- bad_cmd_o  out  1  one-cycle pulse on an unsupported opcode

## Operation
- sclk_i, cs_n_i, mosi_i pass 2-flop synchronizers; rising/falling edges detected on synced sclk. MOSI sampled at sclk rise; MISO updated at sclk fall. Bits MSB first.
- cs_n rising (synced) from any state: abort to IDLE, bit counter cleared, miso_oe_o=0. Partial bytes discarded (no write).
- States: IDLE -> CMD on cs_n fall. CMD shifts 8 bits, then decodes:
  - 0x9F RDID -> OUT, bytes MFR_ID, DEVICE_ID[15:8], DEVICE_ID[7:0], then 0x00 repeating.
  - 0x05 RDSR -> OUT, status byte {6'b0, wel, 1'b0} repeated (WIP always 0).
  - 0x06 WREN: wel set at end of 8th bit. 0x04 WRDI: wel cleared. Then -> IGNORE.
  - 0x03 READ -> ADDR (24 bits) -> OUT. 0x0B FAST_READ -> ADDR -> DUMMY (8 sclk) -> OUT.
  - 0x02 PP -> ADDR -> IN.
  - Other: bad_cmd_o pulse, -> IGNORE (miso_oe_o=0 until cs_n high).
- Address: 24 bits received; low MEM_AW bits used, upper bits ignored.
- OUT (memory reads): mem_rd_o issued at the sclk rise completing the address (or last dummy bit), and again at the rise of bit 0 of each output byte for the next address; address increments modulo 2^MEM_AW (wraps to 0). Byte loaded into shifter before the next sclk fall.
- IN (PP): each complete byte written with mem_wr_o at the same address; address low 8 bits wrap within the 256-byte page (upper bits fixed). If wel=0 at PP decode, bytes are received but no writes issued. Data overwrites (no AND emulation). wel cleared on cs_n rise ending a PP.

## Timing
- Reset: miso_o=0, miso_oe_o=0, mem_rd_o=0, mem_wr_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0, wel_o=0, bad_cmd_o=0, state IDLE.
- Input-to-edge latency 3 clk (2 sync + 1 detect). Requirement: SCLK period ≥ 8 clk, each SCLK phase ≥ 4 clk; cs_n setup to first sclk rise ≥ 4 clk.
- miso_o changes 3 clk after the sclk fall; first output bit driven at the sclk fall after the final command/address/dummy bit; miso_oe_o rises with it.
- mem_rd_o → mem_rdata_i 1 clk; data captured 1 clk after strobe, fits within half SCLK.
- mem_wr_o asserted 1 clk after the rise detect of the 8th data bit.
- Simultaneous cs_n rise and sclk edge in the same clk: cs_n wins; edge ignored.
- rst mid-transaction: immediate return to reset state; transaction resumes only at the next cs_n fall.

## Test plan
- RDID: send 0x9F, clock 24 bits -> MISO 0x20, 0xBA, 0x19; bad_cmd_o never pulses.
- WREN then RDSR: 0x06, cs high, 0x05 -> status 0x02; then 0x04, 0x05 -> 0x00.
- PP without WREN: 0x02 addr 0x000010 data 0xA5 -> zero mem_wr_o pulses; with WREN: one write 0xA5 at 0x10, wel_o=0 after cs high.
- Page wrap: WREN, PP at 0x0001FE, bytes 11,22,33 -> writes at 0x1FE, 0x1FF, 0x100.
- READ wrap: RAM preloaded 0x3FFFF=0xC3, 0x00000=0x3C; 0x03 addr 0x03FFFF, 16 bits -> 0xC3, 0x3C. FAST_READ at same address with 8 dummy -> same bytes.
- Abort/bad opcode: 0x5A -> one bad_cmd_o pulse, miso_oe_o=0; cs high after 12 bits of a PP -> no write, next RDID correct.

Source files
------------

// File: rtl/spi_flash_responder.sv
// SPI mode-0 NOR-flash target for FPGA/emulation builds: oversamples the SPI bus
// in the clk domain and serves RDID/RDSR/WREN/WRDI/READ/FAST_READ/PP from an external byte RAM.
module spi_flash_responder #(
  parameter int          MEM_AW    = 18,
  parameter logic [7:0]  MFR_ID    = 8'h20,
  parameter logic [15:0] DEVICE_ID = 16'hBA19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              mem_wr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              busy_o,
  output logic              wel_o,
  output logic              bad_cmd_o
);

  localparam logic [7:0] OP_RDID = 8'h9F, OP_RDSR = 8'h05, OP_WREN = 8'h06, OP_WRDI = 8'h04;
  localparam logic [7:0] OP_READ = 8'h03, OP_FREAD = 8'h0B, OP_PP = 8'h02;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_OUT, S_IN, S_IGN} state_t;
  typedef enum logic [1:0] {K_ID, K_SR, K_MEM} kind_t;

  logic [1:0]        sclk_s_q, cs_s_q, mosi_s_q;
  logic              sclk_p_q, cs_p_q;
  state_t            state_q;
  kind_t             kind_q;
  logic [4:0]        cnt_q;
  logic [2:0]        obit_q;
  logic [MEM_AW-2:0] sh_q;
  logic [7:0]        cmd_q, out_q, nxt_q, wdata_q;
  logic [MEM_AW-1:0] addr_q, mem_addr_q;
  logic [1:0]        id_idx_q;
  logic              miso_q, oe_q, rd_q, wr_q, bad_q, wel_q, wok_q, rd_dly_q, first_q;

  logic              sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [MEM_AW-1:0] sh_nx;
  logic [7:0]        status, id_byte;

  assign sclk_rise = sclk_s_q[1] & ~sclk_p_q;
  assign sclk_fall = ~sclk_s_q[1] & sclk_p_q;
  assign cs_rise   = cs_s_q[1] & ~cs_p_q;
  assign cs_fall   = ~cs_s_q[1] & cs_p_q;
  // Shifting 24 address bits through an MEM_AW-wide window keeps only the low bits.
  assign sh_nx     = {sh_q, mosi_s_q[1]};
  assign status    = {6'b0, wel_q, 1'b0};

  always_comb begin
    id_byte = 8'h00;
    case (id_idx_q)
      2'd1:    id_byte = DEVICE_ID[15:8];
      2'd2:    id_byte = DEVICE_ID[7:0];
      default: id_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s_q <= 2'b00; cs_s_q <= 2'b11; mosi_s_q <= 2'b00;
      sclk_p_q <= 1'b0;  cs_p_q <= 1'b1;
      state_q <= S_IDLE; kind_q <= K_ID;
      cnt_q <= '0; obit_q <= '0; sh_q <= '0; id_idx_q <= '0;
      cmd_q <= '0; out_q <= '0; nxt_q <= '0; wdata_q <= '0;
      addr_q <= '0; mem_addr_q <= '0;
      miso_q <= 1'b0; oe_q <= 1'b0; rd_q <= 1'b0; wr_q <= 1'b0; bad_q <= 1'b0;
      wel_q <= 1'b0; wok_q <= 1'b0; rd_dly_q <= 1'b0; first_q <= 1'b0;
    end else begin
      sclk_s_q <= {sclk_s_q[0], sclk_i};
      cs_s_q   <= {cs_s_q[0], cs_n_i};
      mosi_s_q <= {mosi_s_q[0], mosi_i};
      sclk_p_q <= sclk_s_q[1];
      cs_p_q   <= cs_s_q[1];
      rd_q <= 1'b0; wr_q <= 1'b0; bad_q <= 1'b0;
      rd_dly_q <= rd_q;
      // RAM answers one clk after the strobe; the first byte goes straight to the shifter.
      if (rd_dly_q) begin
        if (first_q) out_q <= mem_rdata_i;
        else         nxt_q <= mem_rdata_i;
      end
      if (cs_rise) begin
        state_q <= S_IDLE; cnt_q <= '0; obit_q <= '0; oe_q <= 1'b0; miso_q <= 1'b0;
        if (cmd_q == OP_PP && (state_q == S_ADDR || state_q == S_IN)) wel_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (cs_fall) begin state_q <= S_CMD; cnt_q <= '0; end
          S_CMD: if (sclk_rise) begin
            sh_q <= sh_nx[MEM_AW-2:0]; cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_q <= '0; obit_q <= '0; cmd_q <= sh_nx[7:0];
              case (sh_nx[7:0])
                OP_RDID: begin state_q <= S_OUT; kind_q <= K_ID; out_q <= MFR_ID; id_idx_q <= 2'd1; end
                OP_RDSR: begin state_q <= S_OUT; kind_q <= K_SR; out_q <= status; end
                OP_WREN: begin wel_q <= 1'b1; state_q <= S_IGN; end
                OP_WRDI: begin wel_q <= 1'b0; state_q <= S_IGN; end
                OP_READ, OP_FREAD, OP_PP: state_q <= S_ADDR;
                default: begin bad_q <= 1'b1; state_q <= S_IGN; end
              endcase
            end
          end
          S_ADDR: if (sclk_rise) begin
            sh_q <= sh_nx[MEM_AW-2:0]; cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
              cnt_q <= '0;
              if (cmd_q == OP_PP) begin
                addr_q <= sh_nx; wok_q <= wel_q; state_q <= S_IN;
              end else if (cmd_q == OP_FREAD) begin
                addr_q <= sh_nx; state_q <= S_DUMMY;
              end else begin
                mem_addr_q <= sh_nx; rd_q <= 1'b1; first_q <= 1'b1;
                addr_q <= sh_nx + 1'b1; kind_q <= K_MEM; state_q <= S_OUT;
              end
            end
          end
          S_DUMMY: if (sclk_rise) begin
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_q <= '0; mem_addr_q <= addr_q; rd_q <= 1'b1; first_q <= 1'b1;
              addr_q <= addr_q + 1'b1; kind_q <= K_MEM; state_q <= S_OUT;
            end
          end
          S_OUT: begin
            if (sclk_fall) begin
              miso_q <= out_q[7]; oe_q <= 1'b1; obit_q <= obit_q + 3'd1;
              if (obit_q == 3'd7) begin
                case (kind_q)
                  K_ID:    out_q <= id_byte;
                  K_SR:    out_q <= status;
                  default: out_q <= nxt_q;
                endcase
                if (kind_q == K_ID && id_idx_q != 2'd3) id_idx_q <= id_idx_q + 2'd1;
              end else begin
                out_q <= {out_q[6:0], 1'b0};
              end
            end else if (sclk_rise && kind_q == K_MEM && obit_q == 3'd1) begin
              // Prefetch the following byte while the current one is shifting out.
              mem_addr_q <= addr_q; rd_q <= 1'b1; first_q <= 1'b0;
              addr_q <= addr_q + 1'b1;
            end
          end
          S_IN: if (sclk_rise) begin
            sh_q <= sh_nx[MEM_AW-2:0]; cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_q <= '0;
              if (wok_q) begin
                wr_q <= 1'b1; wdata_q <= sh_nx[7:0]; mem_addr_q <= addr_q;
              end
              addr_q[7:0] <= addr_q[7:0] + 8'd1;
            end
          end
          S_IGN: ;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign miso_o      = miso_q;
  assign miso_oe_o   = oe_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_rd_o    = rd_q;
  assign mem_wr_o    = wr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = ~cs_s_q[1];
  assign wel_o       = wel_q;
  assign bad_cmd_o   = bad_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: expected MISO bytes and RAM writes are queued
// by the stimulus and consumed by a monitor that watches the bus and memory port.
module tb_spi_flash_responder;
  localparam int H  = 4;
  localparam int AW = 18;

  logic          clk = 1'b0, rst = 1'b1;
  logic          sclk_i = 1'b0, cs_n_i = 1'b1, mosi_i = 1'b0;
  logic          miso_o, miso_oe_o, mem_rd_o, mem_wr_o, busy_o, wel_o, bad_cmd_o;
  logic [AW-1:0] mem_addr_o;
  logic [7:0]    mem_rdata_i = 8'h00, mem_wdata_o;

  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_a = '0;
  logic [7:0]    pre_d = 8'h00;
  logic [7:0]    mem [0:(1<<AW)-1];

  int errs = 0, checks = 0, bad_cnt = 0;
  bit done = 1'b0;
  logic [7:0]  rd_exp [$];
  logic [25:0] wr_exp [$];

  spi_flash_responder #(.MEM_AW(AW), .MFR_ID(8'h20), .DEVICE_ID(16'hBA19)) dut (
    .clk(clk), .rst(rst), .sclk_i(sclk_i), .cs_n_i(cs_n_i), .mosi_i(mosi_i),
    .miso_o(miso_o), .miso_oe_o(miso_oe_o), .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o),
    .mem_rdata_i(mem_rdata_i), .mem_wr_o(mem_wr_o), .mem_wdata_o(mem_wdata_o),
    .busy_o(busy_o), .wel_o(wel_o), .bad_cmd_o(bad_cmd_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we)        mem[pre_a] <= pre_d;
    else if (mem_wr_o) mem[mem_addr_o] <= mem_wdata_o;
    if (mem_rd_o) mem_rdata_i <= mem[mem_addr_o];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    mosi_i = b; tick(H); sclk_i = 1'b1; tick(H); sclk_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic cs_lo();
    cs_n_i = 1'b0; tick(H);
  endtask

  task automatic cs_hi();
    tick(H); cs_n_i = 1'b1; tick(2*H);
  endtask

  task automatic read_byte(input logic [7:0] exp);
    rd_exp.push_back(exp); send_byte(8'h00);
  endtask

  task automatic cmd_only(input logic [7:0] op);
    cs_lo(); send_byte(op); cs_hi();
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1; tick(1); pre_we = 1'b0;
  endtask

  initial begin
    fork
      begin : stim
        tick(3);
        chk("rst_miso", 32'(miso_o), 0);     chk("rst_oe", 32'(miso_oe_o), 0);
        chk("rst_rd", 32'(mem_rd_o), 0);     chk("rst_wr", 32'(mem_wr_o), 0);
        chk("rst_addr", 32'(mem_addr_o), 0); chk("rst_wdata", 32'(mem_wdata_o), 0);
        chk("rst_busy", 32'(busy_o), 0);     chk("rst_wel", 32'(wel_o), 0);
        chk("rst_bad", 32'(bad_cmd_o), 0);
        rst = 1'b0; tick(4);

        // RDID
        cs_lo(); chk("busy_low", 32'(busy_o), 1);
        send_byte(8'h9F); read_byte(8'h20); read_byte(8'hBA); read_byte(8'h19); read_byte(8'h00);
        cs_hi(); chk("rdid_no_bad", 32'(bad_cnt), 0);

        // WREN / RDSR / WRDI / RDSR
        cmd_only(8'h06); chk("wel_set", 32'(wel_o), 1);
        cs_lo(); send_byte(8'h05); read_byte(8'h02); read_byte(8'h02); cs_hi();
        cmd_only(8'h04); chk("wel_clr", 32'(wel_o), 0);
        cs_lo(); send_byte(8'h05); read_byte(8'h00); cs_hi();

        // PP without WREN: no writes queued
        cs_lo(); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'hA5); cs_hi();
        // PP with WREN
        cmd_only(8'h06);
        cs_lo(); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        wr_exp.push_back({18'h00010, 8'hA5}); send_byte(8'hA5); cs_hi();
        chk("wel_after_pp", 32'(wel_o), 0);

        // Page wrap
        cmd_only(8'h06);
        cs_lo(); send_byte(8'h02); send_byte(8'h00); send_byte(8'h01); send_byte(8'hFE);
        wr_exp.push_back({18'h001FE, 8'h11}); send_byte(8'h11);
        wr_exp.push_back({18'h001FF, 8'h22}); send_byte(8'h22);
        wr_exp.push_back({18'h00100, 8'h33}); send_byte(8'h33);
        cs_hi();

        // READ / FAST_READ across the top of memory
        preload(18'h3FFFF, 8'hC3); preload(18'h00000, 8'h3C);
        cs_lo(); send_byte(8'h03); send_byte(8'h03); send_byte(8'hFF); send_byte(8'hFF);
        read_byte(8'hC3); read_byte(8'h3C); cs_hi();
        cs_lo(); send_byte(8'h0B); send_byte(8'h03); send_byte(8'hFF); send_byte(8'hFF);
        send_byte(8'h00); read_byte(8'hC3); read_byte(8'h3C); cs_hi();

        // Bad opcode
        cs_lo(); send_byte(8'h5A); send_byte(8'hFF);
        chk("bad_oe", 32'(miso_oe_o), 0); cs_hi();
        chk("bad_pulses", 32'(bad_cnt), 1);

        // Abort PP after 12 bits, then RDID still works
        cmd_only(8'h06);
        cs_lo(); send_byte(8'h02); for (int i = 0; i < 4; i++) send_bit(1'b0); cs_hi();
        chk("abort_oe", 32'(miso_oe_o), 0);
        cs_lo(); send_byte(8'h9F); read_byte(8'h20); read_byte(8'hBA); read_byte(8'h19); cs_hi();

        tick(20);
        done = 1'b1;
      end
      begin : mon
        logic sp, cp;
        logic [7:0] sh;
        int nb;
        sp = 1'b0; cp = 1'b1; sh = 8'h00; nb = 0;
        while (!done) begin
          @(negedge clk);
          if (!cs_n_i && cp) nb = 0;
          if (sclk_i && !sp && !cs_n_i && miso_oe_o) begin
            sh = {sh[6:0], miso_o}; nb++;
            if (nb == 8) begin
              nb = 0;
              if (rd_exp.size() == 0) begin
                checks++; errs++;
                $display("FAIL miso_extra: got %0h with no byte expected", sh);
              end else chk("miso_byte", 32'(sh), 32'(rd_exp.pop_front()));
            end
          end
          sp = sclk_i; cp = cs_n_i;
          if (mem_wr_o) begin
            if (wr_exp.size() == 0) begin
              checks++; errs++;
              $display("FAIL wr_extra: got addr %0h data %0h with no write expected",
                       mem_addr_o, mem_wdata_o);
            end else chk("mem_write", 32'({mem_addr_o, mem_wdata_o}), 32'(wr_exp.pop_front()));
          end
          if (bad_cmd_o) bad_cnt++;
        end
      end
    join
    chk("rd_left", 32'(rd_exp.size()), 0);
    chk("wr_left", 32'(wr_exp.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
